iir_biquad_mc: RTL and testbench

Parametrised, multi-channel, time-multiplexed second-order IIR section (Direct Form I) with an internal MAC sequencer, double-banked run-time coefficients and round/saturate output. Replaces the fixed-coefficient filter blocks whose step signals were driven externally. It sits between the sample source and the output register stage of the audio filter chain. One multiplier serves all channels.

---
 rtl/iir_biquad_mc_if.sv | 35 +++
 rtl/iir_biquad_mc.sv | 164 ++++++++++++++++
 tb/tb_iir_biquad_mc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_biquad_mc_if.sv
// Sample, coefficient and result bundle for the multi-channel biquad.
// The master drives samples and coefficient writes; the slave is the filter.
interface iir_biquad_mc_if #(
    parameter int unsigned W   = 25,
    parameter int unsigned CHW = 1
);
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [CHW-1:0]        in_ch;
    logic signed [W-1:0]   in_data;
    logic                  bank_sel;
    logic                  bank_act;
    logic                  coef_we;
    logic                  coef_bank;
    logic [2:0]            coef_addr;
    logic signed [W-1:0]   coef_data;
    logic                  coef_err;
    logic                  out_valid;
    logic [CHW-1:0]        out_ch;
    logic signed [W-1:0]   out_data;
    logic                  out_sat;

    modport master (
        output clear, in_valid, in_ch, in_data, bank_sel,
        output coef_we, coef_bank, coef_addr, coef_data,
        input  in_ready, bank_act, coef_err, out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  clear, in_valid, in_ch, in_data, bank_sel,
        input  coef_we, coef_bank, coef_addr, coef_data,
        output in_ready, bank_act, coef_err, out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed Direct Form I biquad: one multiplier, five MAC cycles per sample,
// per-channel history, double-banked coefficients and round/saturate on the output.
module iir_biquad_mc #(
    parameter int unsigned W    = 25,
    parameter int unsigned FRAC = 15,
    parameter int unsigned NCH  = 2,
    parameter int unsigned CHW  = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    iir_biquad_mc_if.slave bus_io
);
    localparam int unsigned AW = 2 * W + 3;
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMac  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic signed [AW-1:0] RndK = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [AW-1:0] YMax = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] YMin = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  One  = {{(W-1){1'b0}}, 1'b1} << FRAC;

    logic [1:0]           state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [W-1:0]  x_q;
    logic [CHW-1:0]       ch_q;
    logic                 bank_act_q;
    logic signed [W-1:0]  coef_q [2][5];
    logic signed [W-1:0]  x1_q [NCH];
    logic signed [W-1:0]  x2_q [NCH];
    logic signed [W-1:0]  y1_q [NCH];
    logic signed [W-1:0]  y2_q [NCH];
    logic                 out_valid_q, out_sat_q, coef_err_q;
    logic [CHW-1:0]       out_ch_q;
    logic signed [W-1:0]  out_data_q;

    logic                  accept, ch_ok, busy, sat_hi, sat_lo;
    logic signed [W-1:0]   op_c, op_x, y_clip;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  rnd;

    assign busy  = (state_q != StIdle);
    assign ch_ok = 32'(ch_q) < NCH;

    // Out-of-range channels still run the MAC but never touch any history slot.
    always_comb begin
        op_c = coef_q[bank_act_q][k_q];
        case (k_q)
            3'd0:    op_x = x_q;
            3'd1:    op_x = x1_q[ch_q];
            3'd2:    op_x = x2_q[ch_q];
            3'd3:    op_x = y1_q[ch_q];
            3'd4:    op_x = y2_q[ch_q];
            default: op_x = '0;
        endcase
        if (!ch_ok && k_q != 3'd0) op_x = '0;
        prod = op_c * op_x;
    end

    always_comb begin
        rnd    = (acc_q + RndK) >>> FRAC;
        sat_hi = rnd > YMax;
        sat_lo = rnd < YMin;
        y_clip = sat_hi ? YMax[W-1:0] : (sat_lo ? YMin[W-1:0] : rnd[W-1:0]);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.in_valid && !bus_io.clear) begin
                    accept  = 1'b1;
                    state_d = StMac;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            StMac: begin
                acc_d = acc_q + {{3{prod[2*W-1]}}, prod};
                k_d   = k_q + 3'd1;
                if (k_q == 3'd4) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        if (bus_io.clear) state_d = StIdle;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            k_q         <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            ch_q        <= '0;
            bank_act_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 5; j++) begin
                    coef_q[i][j] <= (i == 0 && j == 0) ? One : '0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            if (accept) begin
                x_q        <= bus_io.in_data;
                ch_q       <= bus_io.in_ch;
                bank_act_q <= bus_io.bank_sel;
            end
            // The bank feeding an in-flight sample is write-protected.
            if (bus_io.coef_we && bus_io.coef_addr < 3'd5) begin
                if (busy && bus_io.coef_bank == bank_act_q) begin
                    coef_err_q <= 1'b1;
                end else begin
                    coef_q[bus_io.coef_bank][bus_io.coef_addr] <= bus_io.coef_data;
                end
            end
            if (bus_io.clear) begin
                for (int c = 0; c < NCH; c++) begin
                    x1_q[c] <= '0;
                    x2_q[c] <= '0;
                    y1_q[c] <= '0;
                    y2_q[c] <= '0;
                end
            end else if (state_q == StDone) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= ch_q;
                out_data_q  <= ch_ok ? y_clip : '0;
                out_sat_q   <= ch_ok && (sat_hi || sat_lo);
                if (ch_ok) begin
                    x2_q[ch_q] <= x1_q[ch_q];
                    x1_q[ch_q] <= x_q;
                    y2_q[ch_q] <= y1_q[ch_q];
                    y1_q[ch_q] <= y_clip;
                end
            end
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle) && !bus_io.clear;
    assign bus_io.bank_act  = bank_act_q;
    assign bus_io.coef_err  = coef_err_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_ch    = out_ch_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_sat   = out_sat_q;
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Bench for iir_biquad_mc: directed vector table, multi-cycle corner sequences and
// randomized samples checked against a plain-arithmetic filter model.
module tb_iir_biquad_mc;
    localparam int unsigned W    = 25;
    localparam int unsigned FRAC = 15;
    localparam int unsigned NCH  = 2;
    localparam int unsigned CHW  = 1;
    localparam longint YMAX = 16777215;
    localparam longint YMIN = -16777216;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iir_biquad_mc_if #(.W(W), .CHW(CHW)) bus ();

    iir_biquad_mc #(.W(W), .FRAC(FRAC), .NCH(NCH), .CHW(CHW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: coefficient banks and per-channel history as plain integers.
    longint mc [2][5];
    longint mx1 [NCH];
    longint mx2 [NCH];
    longint my1 [NCH];
    longint my2 [NCH];

    typedef struct {
        int     ch;
        int     x;
        bit     bank;
        longint exp_y;
        bit     exp_sat;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) for (int a = 0; a < 5; a++) mc[b][a] = 0;
        mc[0][0] = 32768;
        model_clear();
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
    endtask

    task automatic model_step(input int ch, input longint x, input bit bank,
                              output longint y, output bit sat);
        longint acc;
        acc = mc[bank][0] * x + mc[bank][1] * mx1[ch] + mc[bank][2] * mx2[ch]
            + mc[bank][3] * my1[ch] + mc[bank][4] * my2[ch];
        y   = (acc + 16384) >>> FRAC;
        sat = 1'b0;
        if (y > YMAX) begin y = YMAX; sat = 1'b1; end
        if (y < YMIN) begin y = YMIN; sat = 1'b1; end
        mx2[ch] = mx1[ch]; mx1[ch] = x;
        my2[ch] = my1[ch]; my1[ch] = y;
    endtask

    // Idle-time write; always allowed, so coef_err must stay low.
    task automatic write_coef(input bit bank, input int addr, input int data);
        bus.coef_we = 1'b1; bus.coef_bank = bank;
        bus.coef_addr = 3'(addr); bus.coef_data = W'(data);
        @(negedge clk);
        bus.coef_we = 1'b0;
        chk("idle_write_no_err", bus.coef_err, 0);
        if (addr < 5) mc[bank][addr] = data;
    endtask

    // Clear in IDLE with in_valid high: the offer must be refused.
    task automatic do_clear();
        bus.clear = 1'b1; bus.in_valid = 1'b1;
        #1 chk("clear_blocks_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        #1 chk("clear_no_accept", bus.in_ready, 1);
        model_clear();
    endtask

    // mode 0: plain sample; 1: protection writes + bank_sel toggle mid-sample;
    // 2: clear at E+3, sample must be aborted.
    task automatic run_sample(input int ch, input int x, input bit bank, input int mode,
                              output longint y_got, output bit sat_got);
        longint ey;
        bit     es;
        bit     busy_bad;
        bit     abort_bad;
        int     n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_ch = CHW'(ch); bus.in_data = W'(x); bus.bank_sel = bank;
        @(negedge clk);
        bus.in_valid = 1'b0;
        busy_bad = 1'b0;
        y_got = 0;
        sat_got = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (!(mode == 2 && c > 3)) busy_bad |= (bus.in_ready !== 1'b0) || (bus.out_valid !== 1'b0);
            if (mode == 1 && c == 2) begin
                bus.coef_we = 1'b1; bus.coef_bank = 1'b1; bus.coef_addr = 3'd0;
                bus.coef_data = 25'sd12345;
            end
            if (mode == 1 && c == 3) begin
                chk("protected_write_err", bus.coef_err, 1);
                bus.coef_bank = 1'b0; bus.coef_data = 25'sd65536;
                bus.bank_sel = ~bank;
            end
            if (mode == 1 && c == 4) begin
                bus.coef_we = 1'b0;
                chk("inactive_write_no_err", bus.coef_err, 0);
                chk("bank_act_held_midsample", bus.bank_act, bank);
                mc[0][0] = 65536;
            end
            if (mode == 2 && c == 3) bus.clear = 1'b1;
            if (mode == 2 && c == 4) bus.clear = 1'b0;
            @(negedge clk);
        end
        chk("busy_flags", busy_bad, 0);
        if (mode == 2) begin
            abort_bad = 1'b0;
            for (int c = 7; c <= 10; c++) begin
                abort_bad |= (bus.out_valid !== 1'b0);
                @(negedge clk);
            end
            chk("abort_no_out_valid", abort_bad, 0);
            model_clear();
            return;
        end
        chk("out_valid_at_7", bus.out_valid, 1);
        model_step(ch, longint'(x), bank, ey, es);
        y_got = longint'(bus.out_data);
        sat_got = bus.out_sat;
        chk("out_data_model", bus.out_data, ey);
        chk("out_sat_model", bus.out_sat, es);
        chk("out_ch", bus.out_ch, ch);
        chk("bank_act", bus.bank_act, bank);
        @(negedge clk);
        chk("out_valid_one_cycle", bus.out_valid, 0);
        chk("out_data_holds", bus.out_data, ey);
    endtask

    initial begin
        longint y;
        bit     s;
        int     x;
        bus.clear = 0; bus.in_valid = 0; bus.in_ch = '0; bus.in_data = '0; bus.bank_sel = 0;
        bus.coef_we = 0; bus.coef_bank = 0; bus.coef_addr = '0; bus.coef_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ch", bus.out_ch, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_coef_err", bus.coef_err, 0);
        chk("rst_bank_act", bus.bank_act, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);

        // Passthrough from the reset bank.
        run_sample(0, 1000, 1'b0, 0, y, s);
        chk("passthrough_1000", y, 1000);

        write_coef(1'b1, 0, 16384);
        write_coef(1'b1, 3, 16384);
        write_coef(1'b0, 0, 98304);
        write_coef(1'b0, 6, 777);
        do_clear();

        // Half-gain with 0.5 feedback: impulse halves each step; constant 100 rounds up at .5.
        vecs[0] = '{0, 16384, 1'b1, 8192, 1'b0};
        vecs[1] = '{1, 100, 1'b1, 50, 1'b0};
        vecs[2] = '{0, 0, 1'b1, 4096, 1'b0};
        vecs[3] = '{1, 100, 1'b1, 75, 1'b0};
        vecs[4] = '{0, 0, 1'b1, 2048, 1'b0};
        vecs[5] = '{1, 100, 1'b1, 88, 1'b0};
        vecs[6] = '{0, 0, 1'b1, 1024, 1'b0};
        vecs[7] = '{1, 100, 1'b1, 94, 1'b0};
        vecs[8] = '{0, 8388608, 1'b0, 16777215, 1'b1};
        vecs[9] = '{0, -8388608, 1'b0, -16777216, 1'b1};
        for (int i = 0; i < 10; i++) begin
            run_sample(vecs[i].ch, vecs[i].x, vecs[i].bank, 0, y, s);
            chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
            chk($sformatf("vec%0d_sat", i), s, vecs[i].exp_sat);
        end

        // Abort a sample with clear, then the next output must carry no history.
        run_sample(0, 5000, 1'b1, 2, y, s);
        run_sample(0, 16384, 1'b1, 0, y, s);
        chk("after_clear_clean", y, 8192);

        // Write protection and mid-sample bank_sel toggle, then read back both banks.
        run_sample(1, 0, 1'b1, 1, y, s);
        do_clear();
        run_sample(0, 16384, 1'b1, 0, y, s);
        chk("bank1_b0_unchanged", y, 8192);
        run_sample(1, 1000, 1'b0, 0, y, s);
        chk("bank0_b0_written", y, 2000);
        chk("bank_act_switched", bus.bank_act, 0);

        // Randomized samples, idle-time coefficient writes and occasional clears.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int a;
                a = $urandom_range(0, 7);
                if (a < 3) write_coef(1'($urandom_range(0, 1)), a,
                                      int'($urandom_range(0, 65536)) - 32768);
                else write_coef(1'($urandom_range(0, 1)), a,
                                int'($urandom_range(0, 32768)) - 16384);
            end
            if ($urandom_range(0, 9) == 0) do_clear();
            x = int'($urandom_range(0, 2097151)) - 1048576;
            run_sample(int'($urandom_range(0, NCH - 1)), x, 1'($urandom_range(0, 1)), 0, y, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
